// File: rtl/aes_pkg.sv
// aes_pkg: shared AES state width, byte type, round-stage FSM states and GF(2^8) helpers
package aes_pkg;
  localparam int AES_STATE_W = 128;
  typedef logic [7:0] aes_byte_t;
  typedef enum logic [1:0] {IDLE_S, RUN_S, DONE_S} aes_state_t;
  function automatic aes_byte_t xtime(aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  // Constants up to 15 suffice for both MixColumns and InvMixColumns.
  function automatic aes_byte_t gf_mul_const(aes_byte_t x, logic [3:0] k);
    aes_byte_t acc;
    aes_byte_t p;
    acc = '0;
    p = x;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction
endpackage

// File: rtl/mix_columns_word.sv
// mix_column_word: combinational single-column (Inv)MixColumns, byte r at a[8r+:8]
module mix_column_word
  import aes_pkg::*;
#(
  parameter bit OP = 1'b1
) (
  input  logic [31:0] a,
  output logic [31:0] s
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    aes_byte_t a0, a1, a2, a3;
    assign a0 = a[8*r+:8];
    assign a1 = a[8*((r+1)%4)+:8];
    assign a2 = a[8*((r+2)%4)+:8];
    assign a3 = a[8*((r+3)%4)+:8];
    assign s[8*r+:8] = OP ? (xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3)
                          : (gf_mul_const(a0, 4'd14) ^ gf_mul_const(a1, 4'd11) ^
                             gf_mul_const(a2, 4'd13) ^ gf_mul_const(a3, 4'd9));
  end
endmodule

// File: rtl/mix_columns.sv
// mix_columns: iterative AES (Inv)MixColumns round stage, one column per cycle, start/done handshake
module mix_columns
  import aes_pkg::*;
#(
  parameter int WIDTH = AES_STATE_W,
  parameter bit OP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b,
  input  logic             last_round,
  input  logic             start,
  output logic [WIDTH-1:0] b_mc,
  output logic             done,
  output logic             busy
);
  if (WIDTH != AES_STATE_W) begin : g_bad_width
    $error("mix_columns supports only WIDTH=128");
  end
  aes_state_t       state, state_n;
  logic [1:0]       col_idx;
  logic [WIDTH-1:0] in_reg, tmp;
  logic             byp;
  logic [31:0]      col, col_mix;
  assign col  = in_reg[{col_idx, 5'b0}+:32];
  assign busy = state != IDLE_S;
  mix_column_word #(.OP(OP)) u_word (.a(col), .s(col_mix));
  always_comb begin
    state_n = IDLE_S;
    state_n = (state == IDLE_S) ? (start ? RUN_S : IDLE_S)
            : (state == RUN_S)  ? ((col_idx == 2'd3) ? DONE_S : RUN_S)
            : IDLE_S;
  end
  always_ff @(posedge clk) state <= rst ? IDLE_S : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx <= '0;
      in_reg  <= '0;
      tmp     <= '0;
      byp     <= 1'b0;
      b_mc    <= '0;
      done    <= 1'b0;
    end else begin
      done <= state == DONE_S;
      if (state == IDLE_S && start) begin
        in_reg  <= b;
        byp     <= last_round;
        col_idx <= '0;
      end
      if (state == RUN_S) begin
        tmp[{col_idx, 5'b0}+:32] <= byp ? col : col_mix;
        col_idx <= col_idx + 2'd1;
      end
      if (state == DONE_S) b_mc <= tmp;
    end
  end
endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns: scoreboard bench for forward and inverse mix_columns instances
module tb_mix_columns;
  typedef struct {
    logic [127:0] d;
    bit           en;
    int           cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [127:0] b_f = '0, b_i = '0, b_mc_f, b_mc_i, last_f = '0;
  logic lr_f = 1'b0, lr_i = 1'b0, start_f = 1'b0, start_i = 1'b0;
  logic done_f, done_i, busy_f, busy_i;
  int cyc = 0, checks = 0, errors = 0;
  exp_t q_f[$], q_i[$];
  localparam logic [127:0] FULL_IN  = 128'hd5d4d4d4_01010101_5c220af2_455313db;
  localparam logic [127:0] FULL_OUT = 128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;
  localparam logic [127:0] HI_IN    = 128'hc6c6c6c6_4c31262d_00000000_00000000;
  localparam logic [127:0] HI_OUT   = 128'hc6c6c6c6_f8bd7e4d_00000000_00000000;
  localparam logic [127:0] BYP_V    = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_columns #(.WIDTH(128), .OP(1'b1)) dut_f (
    .clk(clk), .rst(rst), .b(b_f), .last_round(lr_f), .start(start_f),
    .b_mc(b_mc_f), .done(done_f), .busy(busy_f));
  mix_columns #(.WIDTH(128), .OP(1'b0)) dut_i (
    .clk(clk), .rst(rst), .b(b_i), .last_round(lr_i), .start(start_i),
    .b_mc(b_mc_i), .done(done_i), .busy(busy_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_done(input string nm, input logic [127:0] got, input exp_t e);
    checks++;
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL %s_latency done at cycle %0d, required %0d", nm, cyc, e.cyc);
    end
    if (e.en) begin
      checks++;
      if (got !== e.d) begin
        errors++;
        $display("FAIL %s_data got %h required %h", nm, got, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (done_f) begin
      if (q_f.size() == 0) begin
        checks++; errors++;
        $display("FAIL fwd_unexpected_done at cycle %0d got %h required no done", cyc, b_mc_f);
      end else begin
        last_f = b_mc_f;
        check_done("fwd", b_mc_f, q_f.pop_front());
      end
    end
    if (done_i) begin
      if (q_i.size() == 0) begin
        checks++; errors++;
        $display("FAIL inv_unexpected_done at cycle %0d got %h required no done", cyc, b_mc_i);
      end else check_done("inv", b_mc_i, q_i.pop_front());
    end
  end

  task automatic drain();
    for (int i = 0; i < 30 && (q_f.size() != 0 || q_i.size() != 0); i++) @(negedge clk);
    if (q_f.size() != 0 || q_i.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending fwd=%0d inv=%0d required 0", q_f.size(), q_i.size());
      q_f.delete();
      q_i.delete();
    end
  endtask

  task automatic go(input bit inv, input logic [127:0] x, input bit lr,
                    input logic [127:0] e, input bit en);
    @(negedge clk);
    if (inv) begin
      b_i = x; lr_i = lr; start_i = 1'b1;
      q_i.push_back('{e, en, cyc + 6});
    end else begin
      b_f = x; lr_f = lr; start_f = 1'b1;
      q_f.push_back('{e, en, cyc + 6});
    end
    @(negedge clk);
    start_f = 1'b0; start_i = 1'b0;
    b_f = ~x; b_i = ~x; lr_f = ~lr; lr_i = ~lr;
    drain();
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (b_mc_f !== '0 || done_f !== 1'b0 || busy_f !== 1'b0) begin
      errors++;
      $display("FAIL %s got b_mc=%h done=%b busy=%b required all zero", nm, b_mc_f, done_f, busy_f);
    end
    checks++;
    if (b_mc_i !== '0 || done_i !== 1'b0 || busy_i !== 1'b0) begin
      errors++;
      $display("FAIL %s_inv got b_mc=%h done=%b busy=%b required all zero", nm, b_mc_i, done_i, busy_i);
    end
  endtask

  initial begin
    logic [127:0] x;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    go(1'b0, 128'h455313db, 1'b0, 128'hbca14d8e, 1'b1);
    go(1'b0, FULL_IN, 1'b0, FULL_OUT, 1'b1);
    go(1'b0, HI_IN, 1'b0, HI_OUT, 1'b1);
    go(1'b1, FULL_OUT, 1'b0, FULL_IN, 1'b1);
    go(1'b1, HI_OUT, 1'b0, HI_IN, 1'b1);
    go(1'b0, BYP_V, 1'b1, BYP_V, 1'b1);
    go(1'b1, BYP_V, 1'b1, BYP_V, 1'b1);
    @(negedge clk);
    b_f = FULL_IN; lr_f = 1'b0; start_f = 1'b1;
    for (int k = 1; k <= 3; k++) q_f.push_back('{FULL_OUT, 1'b1, cyc + 6 * k});
    repeat (18) @(negedge clk);
    start_f = 1'b0;
    drain();
    @(negedge clk);
    b_f = HI_IN; start_f = 1'b1;
    q_f.push_back('{HI_OUT, 1'b1, cyc + 6});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start_f = (k == 2 || k == 4);
      b_f = FULL_IN;
    end
    drain();
    repeat (10) @(negedge clk);
    @(negedge clk);
    b_f = FULL_IN; start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("mid_run_reset");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      go(1'b0, x, 1'b0, '0, 1'b0);
      go(1'b1, last_f, 1'b0, x, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
